mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register. Sits at the far end of that interface.
- Takes the registered memory-control bits, address, store data and destination register, and runs a req/ack handshake on the data-memory bus.
- Stalls the upstream pipeline until the access completes.
- Its own registered outputs form the MEM/WB pipeline register feeding write-back.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mem_bus_fsm.sv | 98 +++++++++
 rtl/mem_access_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and MEM-stage state encoding for the memory access unit.
// Optional bus timeout is enabled with the MEM_TIMEOUT_EN macro.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  // Timeout counter is never narrower than 8 bits.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-bus handshake FSM: request/ack sequencing, kill flag and, with
// MEM_TIMEOUT_EN defined, an ACCESS-cycle timeout that aborts to DONE.
module mem_bus_fsm
  import mips_pkg::*;
#(
  parameter int WORD_W         = mips_pkg::WORD_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intterupt,
  input  logic              mem_op,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output mem_state_t        state,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] rdata_cap,
  output logic              kill,
  output logic              bus_err
);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_reg;
  assign bus_err = err_reg;
`else
  assign bus_err = 1'b0;
`endif

  // Gated by reset so the upstream pipeline is released the moment reset asserts.
  assign stall = reset & (((state == IDLE) & mem_op) | (state == ACCESS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_cap <= '0;
      kill      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      err_reg <= 1'b0;
      tmo_cnt <= ((state == ACCESS) && !mem_ack && (tmo_cnt != TO_LAST)) ?
                 tmo_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_we    <= mem_write;
            mem_req   <= 1'b1;
            rdata_cap <= '0;
            kill      <= intterupt;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (intterupt) kill <= 1'b1;
          if (mem_ack) begin
            mem_req   <= 1'b0;
            rdata_cap <= mem_we ? '0 : mem_rdata;
            state     <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == TO_LAST) begin
            mem_req   <= 1'b0;
            rdata_cap <= '0;
            err_reg   <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        DONE: begin
          kill  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives the data-memory handshake via mem_bus_fsm and holds the
// MEM/WB pipeline register. Bus timeout is enabled with MEM_TIMEOUT_EN.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int WORD_W         = mips_pkg::WORD_W,
  parameter int REG_ADDR_W     = mips_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  intterupt,
  input  logic                  MemWriteMEM,
  input  logic                  MemReadMEM,
  input  logic                  MemtoRegMEM,
  input  logic                  RegWriteMEM,
  input  logic [WORD_W-1:0]     ALUoutMEM,
  input  logic [WORD_W-1:0]     memwritedataMEM,
  input  logic [REG_ADDR_W-1:0] regwriteaddrMEM,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_W-1:0]     mem_rdata,
  output logic                  bus_err,
  output logic                  MemtoRegWB,
  output logic                  RegWriteWB,
  output logic [WORD_W-1:0]     ALUoutWB,
  output logic [WORD_W-1:0]     memreaddataWB,
  output logic [REG_ADDR_W-1:0] regwriteaddrWB
);

  mem_state_t        state;
  logic              mem_op;
  logic              kill;
  logic              wb_load;
  logic [WORD_W-1:0] rdata_cap;

  assign mem_op = MemReadMEM | MemWriteMEM;

  mem_bus_fsm #(
    .WORD_W        (WORD_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .intterupt(intterupt),
    .mem_op   (mem_op),
    .mem_write(MemWriteMEM),
    .addr     (ALUoutMEM),
    .wdata    (memwritedataMEM),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .state    (state),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .rdata_cap(rdata_cap),
    .kill     (kill),
    .bus_err  (bus_err)
  );

  // MEM/WB advances whenever EX/MEM does: non-memory ops in IDLE, or the DONE cycle.
  assign wb_load = ((state == IDLE) & ~mem_op) | (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemtoRegWB     <= 1'b0;
      RegWriteWB     <= 1'b0;
      ALUoutWB       <= '0;
      memreaddataWB  <= '0;
      regwriteaddrWB <= '0;
    end else if (wb_load) begin
      MemtoRegWB     <= MemtoRegMEM;
      RegWriteWB     <= RegWriteMEM & ~(intterupt | kill | bus_err);
      ALUoutWB       <= ALUoutMEM;
      memreaddataWB  <= (state == DONE) ? rdata_cap : '0;
      regwriteaddrWB <= regwriteaddrMEM;
    end
  end

endmodule
